// File: rtl/sodor3_itype_lockstep.sv
// Lockstep harness: single-cycle reference vs 3-stage pipeline on RV32I OP-IMM.
// Optional `LOCKSTEP_ASSERT_EN adds an immediate assertion on divergence.
module sodor3_itype_lockstep (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        commit_valid,
    output logic [4:0]  commit_rd,
    output logic [31:0] commit_data,
    output logic        mismatch
);

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [6:0]  OP_IMM = 7'b0010011;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    function automatic logic [31:0] alu(input logic [31:0] ins,
                                        input logic [31:0] a);
        logic [31:0] imm;
        logic [4:0]  sh;
        imm = {{20{ins[31]}}, ins[31:20]};
        sh  = ins[24:20];
        unique case (ins[14:12])
            3'd0: alu = a + imm;
            3'd1: alu = a << sh;
            3'd2: alu = {31'b0, $signed(a) < $signed(imm)};
            3'd3: alu = {31'b0, a < imm};
            3'd4: alu = a ^ imm;
            3'd5: alu = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: alu = a | imm;
            3'd7: alu = a & imm;
        endcase
    endfunction

    // Non-writing instructions collapse to an all-zero tuple so both
    // sides compare equal on bubbles.
    function automatic wb_t retire(input logic [31:0] ins,
                                   input logic [31:0] a);
        wb_t t;
        t = '0;
        if (ins[6:0] == OP_IMM && ins[11:7] != 5'd0) begin
            t.we   = 1'b1;
            t.rd   = ins[11:7];
            t.data = alu(ins, a);
        end
        return t;
    endfunction

    logic [31:0] ref_rf  [32];
    logic [31:0] pipe_rf [32];

    logic [31:0] ref_src;
    wb_t         ref_wb;

    always_comb begin
        ref_src = '0;
        if (instr[19:15] != 5'd0)
            ref_src = ref_rf[instr[19:15]];
        ref_wb = retire(instr, ref_src);
    end

    always_ff @(posedge clk) begin
        if (!reset && ref_wb.we)
            ref_rf[ref_wb.rd] <= ref_wb.data;
    end

    logic [31:0] ifex;
    wb_t         exwb;
    logic [4:0]  ex_rs1;
    logic [31:0] ex_src;
    wb_t         ex_wb;

    always_comb begin
        ex_rs1 = ifex[19:15];
        ex_src = '0;
        if (ex_rs1 != 5'd0) begin
            if (exwb.we && exwb.rd == ex_rs1)
                ex_src = exwb.data;
            else
                ex_src = pipe_rf[ex_rs1];
        end
        ex_wb = retire(ifex, ex_src);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifex <= NOP;
            exwb <= '0;
        end else begin
            ifex <= instr;
            exwb <= ex_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && exwb.we)
            pipe_rf[exwb.rd] <= exwb.data;
    end

    assign commit_valid = exwb.we;
    assign commit_rd    = exwb.rd;
    assign commit_data  = exwb.data;

    wb_t  dly0;
    wb_t  dly1;
    logic diff;

    assign diff = (dly1 != exwb);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly0     <= '0;
            dly1     <= '0;
            mismatch <= 1'b0;
        end else begin
            dly0 <= ref_wb;
            dly1 <= dly0;
            if (diff)
                mismatch <= 1'b1;
        end
    end

`ifdef LOCKSTEP_ASSERT_EN
    logic [31:0] cyc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cyc <= '0;
        else
            cyc <= cyc + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            assert (!diff)
            else $error("lockstep divergence cyc=%0d rd=%0d exp=%h act=%h",
                        cyc, dly1.rd, dly1.data, exwb.data);
    end
`endif

endmodule

// File: tb/tb_sodor3_itype_lockstep.sv
// Directed bench for sodor3_itype_lockstep: hand-encoded OP-IMM vectors,
// bypass, sticky mismatch and a masked random stream.
module tb_sodor3_itype_lockstep;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = NOP;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic        mismatch;

    int total = 0;
    int bad = 0;

    sodor3_itype_lockstep dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .mismatch     (mismatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [31:0] i);
        instr = i;
        @(posedge clk);
        #1;
    endtask

    task automatic commit_is(input string tag, input logic v,
                             input logic [4:0] rd, input logic [31:0] d);
        chk({tag, ".v"}, 32'(commit_valid), 32'(v));
        chk({tag, ".rd"}, 32'(commit_rd), 32'(rd));
        chk({tag, ".d"}, commit_data, d);
    endtask

    logic [31:0] tab_i [7];
    logic        tab_v [7];
    logic [4:0]  tab_rd [7];
    logic [31:0] tab_d [7];

    initial begin
        logic [31:0] v;
        logic [31:0] r;

        // x1=5, x5=-1, the rest a fixed pattern; identical in both files
        for (int i = 0; i < 32; i++) begin
            v = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
            if (i == 1) v = 32'd5;
            if (i == 5) v = 32'hFFFFFFFF;
            dut.ref_rf[i]  = v;
            dut.pipe_rf[i] = v;
        end

        for (int i = 0; i < 3; i++) begin
            step(NOP);
            chk("rst.cv", 32'(commit_valid), 32'd0);
            chk("rst.mm", 32'(mismatch), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(NOP);
            chk("nop.cv", 32'(commit_valid), 32'd0);
            chk("nop.mm", 32'(mismatch), 32'd0);
        end

        // ADDI x2,x1,-7
        step(32'hFF908113);
        chk("addi.early", 32'(commit_valid), 32'd0);
        step(NOP);
        commit_is("addi", 1'b1, 5'd2, 32'hFFFFFFFE);
        chk("addi.mm", 32'(mismatch), 32'd0);

        // ADDI x3,x0,1 ; SLLI x3,x3,31 ; SRAI x4,x3,4
        step(32'h00100193);
        step(32'h01F19193);
        commit_is("li", 1'b1, 5'd3, 32'h00000001);
        step(32'h4041D213);
        commit_is("slli", 1'b1, 5'd3, 32'h80000000);
        step(NOP);
        commit_is("srai", 1'b1, 5'd4, 32'hF8000000);

        // SLTI x6,x5,1 ; SLTIU x7,x5,1
        step(32'h0012A313);
        step(32'h0012B393);
        commit_is("slti", 1'b1, 5'd6, 32'd1);
        step(NOP);
        commit_is("sltiu", 1'b1, 5'd7, 32'd0);
        chk("slt.mm", 32'(mismatch), 32'd0);

        tab_i[0] = 32'hFFF0C413; tab_v[0] = 1; tab_rd[0] = 8;  tab_d[0] = 32'hFFFFFFFA;
        tab_i[1] = 32'h0300E493; tab_v[1] = 1; tab_rd[1] = 9;  tab_d[1] = 32'h00000035;
        tab_i[2] = 32'h0040F513; tab_v[2] = 1; tab_rd[2] = 10; tab_d[2] = 32'h00000004;
        tab_i[3] = 32'h01C2D593; tab_v[3] = 1; tab_rd[3] = 11; tab_d[3] = 32'h0000000F;
        tab_i[4] = 32'h001001B3; tab_v[4] = 0; tab_rd[4] = 0;  tab_d[4] = 32'h0;
        tab_i[5] = 32'h00108013; tab_v[5] = 0; tab_rd[5] = 0;  tab_d[5] = 32'h0;
        tab_i[6] = 32'h00140613; tab_v[6] = 1; tab_rd[6] = 12; tab_d[6] = 32'hFFFFFFFB;
        for (int j = 0; j <= 7; j++) begin
            step(j < 7 ? tab_i[j] : NOP);
            if (j > 0)
                commit_is($sformatf("tab%0d", j - 1), tab_v[j-1],
                          tab_rd[j-1], tab_d[j-1]);
        end
        chk("tab.mm", 32'(mismatch), 32'd0);

        // fresh random preload under reset, then a hazard-dense stream
        reset = 1'b1;
        #1;
        chk("rst2.cv", 32'(commit_valid), 32'd0);
        for (int i = 0; i < 32; i++) begin
            v = $urandom;
            dut.ref_rf[i]  = v;
            dut.pipe_rf[i] = v;
        end
        step(NOP);
        reset = 1'b0;
        for (int n = 0; n < 100; n++) begin
            r = $urandom;
            r[6:0] = ($urandom_range(0, 7) == 0) ? 7'h33 : 7'h13;
            r[11:10] = 2'b00;
            r[19:18] = 2'b00;
            if (r[14:12] == 3'd1) r[31:25] = 7'd0;
            if (r[14:12] == 3'd5) begin
                r[31] = 1'b0;
                r[29:25] = 5'd0;
            end
            step(r);
            chk("rnd.mm", 32'(mismatch), 32'd0);
        end
        step(NOP);
        step(NOP);
        chk("rnd.end", 32'(mismatch), 32'd0);

        // diverge x12 between the engines, then read it
        dut.ref_rf[12]  = 32'h00000100;
        dut.pipe_rf[12] = 32'h00000200;
        step(32'h00060693);
        chk("frc.k", 32'(mismatch), 32'd0);
        step(NOP);
        chk("frc.k1", 32'(mismatch), 32'd0);
        commit_is("frc.c", 1'b1, 5'd13, 32'h00000200);
        step(NOP);
        chk("frc.k2", 32'(mismatch), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(NOP);
            chk("frc.sticky", 32'(mismatch), 32'd1);
        end

        // in-flight instruction flushed by an asynchronous reset
        step(32'hFF908113);
        step(NOP);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.mm", 32'(mismatch), 32'd0);
        chk("arst.cv", 32'(commit_valid), 32'd0);
        step(NOP);
        reset = 1'b0;
        step(NOP);
        chk("post.cv", 32'(commit_valid), 32'd0);
        chk("post.mm", 32'(mismatch), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sodor3_itype_lockstep.md
# sodor3_itype_lockstep

Lockstep self-checking harness for the Sodor 3-stage core on the RV32I register-immediate ALU subset. Each cycle it accepts one instruction word and executes it on two engines: a single-cycle architectural reference model and a 3-stage pipelined implementation (IF/EX, EX/WB, WB) with WB→EX bypass. It compares every pipeline commit against the reference commit, aligned by a 2-stage delay, and keeps a sticky mismatch flag. It sits at the top of the formal/simulation verification environment, directly under the bench.

## Interface
- No parameters.
- `clk` in 1 — single clock, rising-edge.
- `reset` in 1 — asynchronous, active-high.
- `instr` in 32 — instruction word, valid every cycle; no handshake.
- `commit_valid` out 1 — pipeline WB stage holds a writing instruction.
- `commit_rd` out 5 — destination register of the WB-stage instruction.
- `commit_data` out 32 — result of the WB-stage instruction.
- `mismatch` out 1 — sticky; set on the first divergence between pipeline and reference.

## Operation
- Decode: opcode 7'b0010011 is an I-type ALU instruction. Any other opcode is a NOP with no register write.
  - Immediate: `instr[31:20]`, sign-extended.
  - Source and destination: `rs1=instr[19:15]`, `rd=instr[11:7]`.
- funct3 behaviour:
  - 0 ADDI: wrap-around add.
  - 2 SLTI: signed compare, result 0/1.
  - 3 SLTIU: unsigned compare, result 0/1.
  - 4 XORI, 6 ORI, 7 ANDI.
  - 1 SLLI: shamt = `imm[4:0]`.
  - 5 SRLI/SRAI: shamt = `imm[4:0]`; `imm[10]` = 1 selects arithmetic shift.
  - Other immediate bits are ignored for shifts.
- `rd==0` never writes. Reads of x0 return 0 in both engines.
- Reference model: 32×32 register file `ref_rf`. It reads `rs1` from `instr`, computes the result combinationally, and writes `ref_rf[rd]` at the same edge that samples `instr`.
- Pipeline model: 32×32 register file `pipe_rf`.
  - IF/EX register captures `instr`.
  - EX reads `pipe_rf[rs1]` combinationally. If the EX/WB instruction writes the same nonzero register, EX forwards that result instead.
  - EX/WB register holds valid, rd and result.
  - `pipe_rf` is written from EX/WB at the next edge.
- Checker: a 2-deep delay line of reference tuples (we, rd, data), with we = I-type && rd≠0.
  - Each edge, the checker compares the tuple leaving the delay line with the (`commit_valid`, `commit_rd`, `commit_data`) tuple.
  - Any field difference sets `mismatch`.
- Both register files are left unreset. They are exposed hierarchically as `ref_rf` and `pipe_rf` so the bench can preload identical values at time 0. Lockstep correctness requires identical initial contents.

## Timing
- `instr` is sampled at edge k.
  - The reference writes `ref_rf` at edge k.
  - The pipeline instruction enters IF/EX at edge k, reaches EX/WB at edge k+1, and writes `pipe_rf` and is compared at edge k+2.
- Commit outputs are registered and reflect EX/WB during the cycle between k+1 and k+2.
- Reset values, applied asynchronously while `reset`=1:
  - IF/EX = 32'h00000013 (NOP).
  - EX/WB valid = 0.
  - Delay line entries invalid (we=0).
  - `mismatch`=0, `commit_valid`=0, `commit_rd`=0, `commit_data`=0.
- While `reset`=1:
  - `instr` is ignored.
  - Neither register file is written.
- Reset asserted mid-operation flushes in-flight instructions in both engines. Register files keep their contents.
- Back-to-back dependency (producer in WB, consumer in EX) uses the bypass.
  - A producer two or more instructions older has already written `pipe_rf`.
  - WB writes before EX reads of the next cycle; no internal write-through is needed.
- Once `mismatch` is set, only reset clears it.

## Configuration
- `LOCKSTEP_ASSERT_EN`:
  - Defined: an immediate assertion fires `$error` with cycle, rd, expected data and actual data at the edge a mismatch is detected.
  - Undefined: the divergence is reported only through `mismatch`.

## Test plan
- Reset held 3 cycles, then 32'h00000013 streamed → `commit_valid`=0 and `mismatch`=0 throughout.
- x1=5 preloaded; ADDI x2,x1,-7 (32'hFF908113) → 2 edges later `commit_valid`=1, `commit_rd`=2, `commit_data`=32'hFFFFFFFE, `mismatch`=0.
- ADDI x3,x0,1 then SLLI x3,x3,31 back-to-back → second commit data 32'h80000000 via bypass. SRAI x4,x3,4 then gives 32'hF8000000.
- SLTI versus SLTIU with x5=32'hFFFFFFFF and imm=1 → results 1 and 0 respectively.
- Hierarchical force of one `pipe_rf` entry differing from `ref_rf`, then an instruction reading it → `mismatch` rises 2 edges later and stays high until reset.
- Random I-type stream (shift immediates masked to legal shamt/`imm[10]`) with equal random register preload for 100 cycles → `mismatch` remains 0.
